// File: rtl/pc_gen_if.sv
// Fetch-port bundle between the PC generator and instruction memory.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;

    modport master (
        output fetch_valid,
        output pc,
        output pc_plus,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  pc,
        input  pc_plus,
        output fetch_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter generator.
// Holds the fetch PC and selects the next value from trap, branch, jump-register,
// return-stack or sequential sources. A small circular return-address stack
// predicts return targets.
module pc_gen #(
    parameter int unsigned    XLEN       = 32,
    parameter int unsigned    INST_BYTES = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned    RAS_DEPTH  = 4
) (
    input  logic            CLK,
    input  logic            RST,
    pc_gen_if.master        fif,
    input  logic            halt,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_offset,
    input  logic            jr_taken,
    input  logic [XLEN-1:0] jr_target,
    input  logic            call,
    input  logic [XLEN-1:0] call_ret,
    input  logic            ret,
    output logic            ras_empty,
    output logic            ras_err,
    output logic            misalign
);
    localparam int unsigned    PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned    CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state;
    logic [XLEN-1:0]  pc_q;
    logic             valid_q;
    logic             ras_err_q;
    logic             misalign_q;
    logic [XLEN-1:0]  ras [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;

    logic             active;
    logic             hard_redir;
    logic             ret_win;
    logic             do_pop;
    logic             ret_fail;
    logic             do_push;
    logic             redirect;
    logic             accept;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  raw_target;

    assign fif.pc          = pc_q;
    assign fif.pc_plus     = pc_q + STEP;
    assign fif.fetch_valid = valid_q;
    assign ras_empty       = (count == '0);
    assign ras_err         = ras_err_q;
    assign misalign        = misalign_q;

    // Redirect arbitration and RAS push/pop decisions for this cycle.
    always_comb begin
        active     = (state != BOOT);
        hard_redir = active & (trap | br_taken | jr_taken);
        ret_win    = (state == RUN) & ret & ~(trap | br_taken | jr_taken);
        do_pop     = ret_win & (count != '0);
        ret_fail   = ret_win & (count == '0);
        do_push    = active & call;
        redirect   = hard_redir | do_pop;
        accept     = valid_q & fif.fetch_ready;
        br_target  = br_pc + br_offset;
        raw_target = ras[top];
        if (trap) begin
            raw_target = trap_vec;
        end else if (br_taken) begin
            raw_target = br_target;
        end else if (jr_taken) begin
            raw_target = jr_target;
        end
    end

    // FSM, PC register and status pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= BOOT;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            ras_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            ras_err_q  <= ret_fail;
            misalign_q <= redirect & (|(raw_target & LOW_MASK));

            if (redirect) begin
                pc_q <= raw_target & ~LOW_MASK;
            end else if (accept) begin
                pc_q <= pc_q + STEP;
            end

            case (state)
                BOOT: begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    // halt only takes effect on a plain sequential accept
                    if (!redirect && accept && halt) begin
                        state   <= HALTED;
                        valid_q <= 1'b0;
                    end
                end
                HALTED: begin
                    if (hard_redir) begin
                        state   <= RUN;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Return-address stack: pop-then-push when both happen in one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            top   <= PTR_W'(RAS_DEPTH - 1);
            count <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else begin
            if (do_push && do_pop) begin
                ras[top] <= call_ret;
            end else if (do_push) begin
                // when full, top+1 is the oldest entry and gets overwritten
                ras[top + PTR_W'(1)] <= call_ret;
                top                  <= top + PTR_W'(1);
                if (count != FULL) begin
                    count <= count + CNT_W'(1);
                end
            end else if (do_pop) begin
                top   <= top - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for the fetch PC generator.
module tb_pc_gen;
    logic        clk;
    logic        rst;
    logic        halt;
    logic        trap;
    logic [31:0] trap_vec;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_offset;
    logic        jr_taken;
    logic [31:0] jr_target;
    logic        call;
    logic [31:0] call_ret;
    logic        ret;
    logic        ras_empty;
    logic        ras_err;
    logic        misalign;

    int compared;
    int mismatched;

    pc_gen_if #(.XLEN(32)) fif ();

    pc_gen #(
        .XLEN      (32),
        .INST_BYTES(4),
        .RESET_VEC (32'h100),
        .RAS_DEPTH (4)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .fif      (fif),
        .halt     (halt),
        .trap     (trap),
        .trap_vec (trap_vec),
        .br_taken (br_taken),
        .br_pc    (br_pc),
        .br_offset(br_offset),
        .jr_taken (jr_taken),
        .jr_target(jr_target),
        .call     (call),
        .call_ret (call_ret),
        .ret      (ret),
        .ras_empty(ras_empty),
        .ras_err  (ras_err),
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        halt;
        logic        trap;
        logic [31:0] tv;
        logic        br;
        logic [31:0] bpc;
        logic [31:0] boff;
        logic        jr;
        logic [31:0] jt;
        logic        call;
        logic [31:0] cr;
        logic        ret;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_mis;
        logic        e_err;
        logic        e_empty;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rdy, input logic [31:0] epc, input logic eemp);
        vec_t v;
        v.ready = rdy;   v.halt = 1'b0;  v.trap = 1'b0; v.tv = '0;
        v.br = 1'b0;     v.bpc = '0;     v.boff = '0;   v.jr = 1'b0; v.jt = '0;
        v.call = 1'b0;   v.cr = '0;      v.ret = 1'b0;
        v.e_pc = epc;    v.e_valid = 1'b1; v.e_mis = 1'b0; v.e_err = 1'b0;
        v.e_empty = eemp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        fif.fetch_ready = 1'b0; halt = 1'b0; trap = 1'b0; trap_vec = '0;
        br_taken = 1'b0; br_pc = '0; br_offset = '0; jr_taken = 1'b0; jr_target = '0;
        call = 1'b0; call_ret = '0; ret = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        compared   = 0;
        mismatched = 0;
        clear_inputs();
        rst = 1'b1;

        // BOOT -> RUN, sequential fetch, ready stalls
        v = mk(1, 32'h100, 1); tbl.push_back(v);
        v = mk(1, 32'h104, 1); tbl.push_back(v);
        v = mk(0, 32'h104, 1); tbl.push_back(v);
        v = mk(0, 32'h104, 1); tbl.push_back(v);
        v = mk(0, 32'h104, 1); tbl.push_back(v);
        v = mk(1, 32'h108, 1); tbl.push_back(v);
        // redirect priority, branch, misaligned jr / trap
        v = mk(1, 32'h80, 1); v.trap = 1; v.tv = 32'h80; v.br = 1; v.bpc = 32'h200;
        v.boff = 32'hFFFF_FFF0; v.jr = 1; v.jt = 32'h500; tbl.push_back(v);
        v = mk(1, 32'h1F0, 1); v.br = 1; v.bpc = 32'h200; v.boff = 32'hFFFF_FFF0; tbl.push_back(v);
        v = mk(0, 32'h300, 1); v.jr = 1; v.jt = 32'h303; v.e_mis = 1; tbl.push_back(v);
        v = mk(1, 32'h304, 1); tbl.push_back(v);
        v = mk(0, 32'h80, 1); v.trap = 1; v.tv = 32'h81; v.e_mis = 1; tbl.push_back(v);
        // five calls into a four-deep stack, then five returns
        v = mk(1, 32'h84, 0); v.call = 1; v.cr = 32'h10; tbl.push_back(v);
        v = mk(1, 32'h88, 0); v.call = 1; v.cr = 32'h20; tbl.push_back(v);
        v = mk(1, 32'h8C, 0); v.call = 1; v.cr = 32'h30; tbl.push_back(v);
        v = mk(1, 32'h90, 0); v.call = 1; v.cr = 32'h40; tbl.push_back(v);
        v = mk(1, 32'h94, 0); v.call = 1; v.cr = 32'h50; tbl.push_back(v);
        v = mk(1, 32'h50, 0); v.ret = 1; tbl.push_back(v);
        v = mk(1, 32'h40, 0); v.ret = 1; tbl.push_back(v);
        v = mk(1, 32'h30, 0); v.ret = 1; tbl.push_back(v);
        v = mk(1, 32'h20, 1); v.ret = 1; tbl.push_back(v);
        v = mk(1, 32'h24, 1); v.ret = 1; v.e_err = 1; tbl.push_back(v);
        v = mk(1, 32'h28, 1); tbl.push_back(v);
        // call + ret in the same cycle replaces top
        v = mk(1, 32'h2C, 0); v.call = 1; v.cr = 32'h10; tbl.push_back(v);
        v = mk(1, 32'h30, 0); v.call = 1; v.cr = 32'h20; tbl.push_back(v);
        v = mk(1, 32'h20, 0); v.call = 1; v.cr = 32'h60; v.ret = 1; tbl.push_back(v);
        v = mk(1, 32'h60, 0); v.ret = 1; tbl.push_back(v);
        v = mk(1, 32'h10, 1); v.ret = 1; tbl.push_back(v);
        // a ret that loses to jr must not pop
        v = mk(1, 32'h14, 0); v.call = 1; v.cr = 32'h70; tbl.push_back(v);
        v = mk(1, 32'h200, 0); v.ret = 1; v.jr = 1; v.jt = 32'h200; tbl.push_back(v);
        v = mk(1, 32'h70, 1); v.ret = 1; tbl.push_back(v);
        // branch target wraps modulo 2^32
        v = mk(1, 32'h8, 1); v.br = 1; v.bpc = 32'hFFFF_FFF8; v.boff = 32'h10; tbl.push_back(v);
        // halt on accept, ret ignored while halted, branch resumes
        v = mk(1, 32'hC, 1); v.halt = 1; v.e_valid = 0; tbl.push_back(v);
        v = mk(1, 32'hC, 1); v.ret = 1; v.e_valid = 0; tbl.push_back(v);
        v = mk(1, 32'hC, 1); v.e_valid = 0; tbl.push_back(v);
        v = mk(1, 32'h400, 1); v.br = 1; v.bpc = 32'h400; tbl.push_back(v);
        v = mk(1, 32'h404, 1); tbl.push_back(v);
        // halt without accept has no effect
        v = mk(0, 32'h404, 1); v.halt = 1; tbl.push_back(v);
        v = mk(1, 32'h408, 1); tbl.push_back(v);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst pc", fif.pc, 32'h100);
        chk("rst pc_plus", fif.pc_plus, 32'h104);
        chk("rst valid", 32'(fif.fetch_valid), 32'h0);
        chk("rst empty", 32'(ras_empty), 32'h1);
        chk("rst err", 32'(ras_err), 32'h0);
        chk("rst misalign", 32'(misalign), 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            fif.fetch_ready = tbl[i].ready;
            halt      = tbl[i].halt;
            trap      = tbl[i].trap;   trap_vec  = tbl[i].tv;
            br_taken  = tbl[i].br;     br_pc     = tbl[i].bpc; br_offset = tbl[i].boff;
            jr_taken  = tbl[i].jr;     jr_target = tbl[i].jt;
            call      = tbl[i].call;   call_ret  = tbl[i].cr;
            ret       = tbl[i].ret;
            step();
            chk($sformatf("r%0d pc", i), fif.pc, tbl[i].e_pc);
            chk($sformatf("r%0d pc_plus", i), fif.pc_plus, tbl[i].e_pc + 32'h4);
            chk($sformatf("r%0d valid", i), 32'(fif.fetch_valid), 32'(tbl[i].e_valid));
            chk($sformatf("r%0d misalign", i), 32'(misalign), 32'(tbl[i].e_mis));
            chk($sformatf("r%0d ras_err", i), 32'(ras_err), 32'(tbl[i].e_err));
            chk($sformatf("r%0d ras_empty", i), 32'(ras_empty), 32'(tbl[i].e_empty));
        end

        // mid-run reset clears pc, valid and the RAS immediately
        clear_inputs();
        fif.fetch_ready = 1'b1;
        call = 1'b1; call_ret = 32'h55;
        step();
        chk("pre-rst pc", fif.pc, 32'h40C);
        chk("pre-rst empty", 32'(ras_empty), 32'h0);
        call = 1'b0;
        rst = 1'b1;
        #1;
        chk("async rst pc", fif.pc, 32'h100);
        chk("async rst valid", 32'(fif.fetch_valid), 32'h0);
        chk("async rst empty", 32'(ras_empty), 32'h1);
        step();
        rst = 1'b0;
        // redirect during BOOT is ignored
        trap = 1'b1; trap_vec = 32'h80;
        step();
        chk("boot pc", fif.pc, 32'h100);
        chk("boot->run valid", 32'(fif.fetch_valid), 32'h1);
        trap = 1'b0;
        step();
        chk("post-rst seq pc", fif.pc, 32'h104);
        // RAS really cleared: ret now errors
        ret = 1'b1;
        step();
        chk("post-rst ret pc", fif.pc, 32'h108);
        chk("post-rst ret err", 32'(ras_err), 32'h1);
        ret = 1'b0;
        step();
        chk("err pulse ends", 32'(ras_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage. It holds the architectural fetch PC and offers it to instruction memory over a valid/ready handshake. It selects the next PC from trap, branch, jump-register, return or sequential sources. A small return-address stack (RAS) predicts return targets. It sits between the decode/execute redirect logic and the instruction-fetch port.

Parameters:
XLEN, 32, width of PC and all address ports
INST_BYTES, 4, sequential increment; power of two; target low log2(INST_BYTES) bits forced to zero
RESET_VEC, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries; power of two, >=2

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
fetch_valid  out  1  pc is offered to fetch
fetch_ready  in  1  fetch accepts pc this cycle
pc  out  XLEN  current fetch PC
pc_plus  out  XLEN  pc + INST_BYTES (combinational)
halt  in  1  enter HALTED after current accept
trap  in  1  redirect to trap_vec
trap_vec  in  XLEN  trap target
br_taken  in  1  PC-relative branch redirect
br_pc  in  XLEN  PC of branch instruction
br_offset  in  XLEN  signed offset, two's complement
jr_taken  in  1  register-indirect jump redirect
jr_target  in  XLEN  jump target
call  in  1  push call_ret onto RAS
call_ret  in  XLEN  return address to push
ret  in  1  redirect to RAS top and pop
ras_empty  out  1  RAS holds no entries
ras_err  out  1  one-cycle pulse: ret on empty RAS
misalign  out  1  one-cycle pulse: selected redirect target had nonzero low bits

Behaviour:
- Reset (async assert): pc=RESET_VEC, state=BOOT, fetch_valid=0, RAS count=0, ras_empty=1, ras_err=0, misalign=0.
- FSM states: BOOT, RUN, HALTED.
- BOOT: lasts one cycle after RST deasserts, then moves to RUN. fetch_valid=0. Redirects are ignored in BOOT.
- RUN: fetch_valid=1.
  - Accept = fetch_valid & fetch_ready.
  - On accept with no redirect: pc <= pc_plus.
- HALTED: fetch_valid=0 and pc holds.
  - halt sampled in RUN on an accept: pc advances, then state becomes HALTED.
  - halt with no accept has no effect until the next accept.
  - Leave HALTED only on trap, br_taken or jr_taken. Load the target and go to RUN.
- Redirect priority, evaluated every cycle in RUN/HALTED regardless of fetch_ready: trap > br_taken > jr_taken > ret > sequential.
  - Branch target = br_pc + br_offset, modulo 2^XLEN (wrap, no overflow flag).
  - A redirect overrides any accept: pc loads the target at the next edge. The offered-but-unaccepted pc is dropped; this is the only case where pc changes while valid is high without an accept.
  - ret is ignored in HALTED.
- Alignment: the selected target has its low bits cleared before loading. misalign pulses in the following cycle if any cleared bit was 1. Sequential increments never set misalign.
- RAS: circular buffer, top pointer plus count (0..RAS_DEPTH).
  - ret honoured only if it is the winning redirect source and count>0. pc <= top, then pop.
  - ret with count==0: no redirect, pc follows the sequential rule, ras_err pulses next cycle.
  - A ret that loses priority does not pop.
  - call pushes when count==RAS_DEPTH: overwrite the oldest entry, count stays at RAS_DEPTH.
  - call and honoured ret in the same cycle: pop, then push. Net result: top replaced, count unchanged.
  - trap does not alter the RAS. call is still honoured in a trap cycle.
- RST asserted mid-operation: immediate return to reset values. The RAS is cleared.
- Latency: redirect input to new pc visible is 1 cycle. pc_plus and ras_empty are combinational from registered state.

Test Plan:
1. Reset release, RESET_VEC=0x100, fetch_ready=1 -> valid low for 1 cycle, then pc = 0x100, 0x104, 0x108.
2. fetch_ready=0 for 3 cycles at pc=0x104 -> pc holds at 0x104 with valid high; ready=1 -> pc becomes 0x108.
3. trap (vec 0x80), br_taken (br_pc 0x200, offset -0x10) and jr_taken all asserted in the same cycle -> pc=0x80. Next cycle, br_taken alone -> pc=0x1F0. jr_target=0x303 -> pc=0x300, misalign=1 for one cycle.
4. RAS_DEPTH=4: five calls pushing 0x10..0x50, then five rets -> targets 0x50, 0x40, 0x30, 0x20. Fifth ret gives ras_err=1, sequential pc, ras_empty=1.
5. call(0x60) and ret in the same cycle with top 0x20, count 2 -> pc=0x20, new top 0x60, count 2.
6. halt on accept at pc=0x104 -> pc=0x108, valid=0. ret in HALTED is ignored. br_taken (0x400) -> RUN, pc=0x400. RST pulsed mid-run -> pc=RESET_VEC immediately, valid=0.
